// File: rtl/vram_glyph_writer.sv
// vram_glyph_writer
// Write side of the 4-slot hex glyph display. Each slot holds a 4-bit glyph
// code that is advanced by a falling edge on its letter button. Whenever a
// code changes, the slot is marked pending and its glyph bitmap is copied row
// by row from the synchronous glyph ROM into that slot's VRAM region.
//
// Optional build macro: VRAM_GLYPH_WRITER_VBLANK_GATE_EN
//   defined   -> starting a redraw and fetching each next row wait for VBlank=1
//   undefined -> VBlank is ignored, rows are written back to back
//
// Ports:
//   Clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   Letra      raw letter buttons, bit i = slot i, falling edge = press
//   VBlank     vertical blanking flag (only used with the gate macro)
//   GlyphAddr  glyph ROM address {code, row}
//   GlyphData  glyph ROM data, valid one cycle after GlyphAddr
//   WrValid    VRAM row write request
//   WrReady    VRAM accepts the write
//   WrRegion   target slot/region
//   WrFila     target row
//   WrData     row bitmap, MSB = leftmost pixel
//   Selector   current codes, slot i at [4i+3:4i]
//   Busy       redraw in progress
//   Done       one-cycle pulse after the last row of a slot is accepted
module vram_glyph_writer #(
  parameter int FONT_W = 150,
  parameter int FONT_H = 523,
  parameter int ROW_W  = 10
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [3:0]            Letra,
  input  logic                  VBlank,
  output logic [4+ROW_W-1:0]    GlyphAddr,
  input  logic [FONT_W-1:0]     GlyphData,
  output logic                  WrValid,
  input  logic                  WrReady,
  output logic [1:0]            WrRegion,
  output logic [ROW_W-1:0]      WrFila,
  output logic [FONT_W-1:0]     WrData,
  output logic [15:0]           Selector,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FONT_H - 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            sync1_reg, sync2_reg, prev_reg;
  logic [3:0]            press;
  logic [15:0]           selector_reg, selector_next;
  logic [3:0]            pending_reg, pending_next, clear_mask;
  logic [1:0]            slot_reg, slot_next, pick_slot;
  logic [3:0]            code_reg, code_next, pick_code;
  logic [ROW_W-1:0]      row_reg, row_next;
  logic [4+ROW_W-1:0]    glyph_addr_reg, glyph_addr_next;
  logic                  wr_valid_reg, wr_valid_next;
  logic [FONT_W-1:0]     wr_data_reg, wr_data_next;
  logic [ROW_W-1:0]      wr_fila_reg, wr_fila_next;
  logic [1:0]            wr_region_reg, wr_region_next;
  logic                  done_reg, done_next;
  logic                  gate;

`ifdef VRAM_GLYPH_WRITER_VBLANK_GATE_EN
  assign gate = VBlank;
`else
  logic unused_vblank;
  assign unused_vblank = VBlank;
  assign gate = 1'b1;
`endif

  // Falling edge seen on the synchronized button: was 1, now 0.
  assign press = prev_reg & ~sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign selector_next[4*gi +: 4] = press[gi] ? selector_reg[4*gi +: 4] + 4'd1
                                                  : selector_reg[4*gi +: 4];
    end
  endgenerate

  // A press in the same cycle as the clear wins, so the slot is redrawn again.
  assign pending_next = (pending_reg & ~clear_mask) | press;

  // Lowest-index pending slot.
  always_comb begin
    pick_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_reg[i]) pick_slot = 2'(i);
    end
  end
  assign pick_code = selector_reg[{pick_slot, 2'b00} +: 4];

  always_comb begin
    state_next      = state_reg;
    slot_next       = slot_reg;
    code_next       = code_reg;
    row_next        = row_reg;
    glyph_addr_next = glyph_addr_reg;
    wr_valid_next   = wr_valid_reg;
    wr_data_next    = wr_data_reg;
    wr_fila_next    = wr_fila_reg;
    wr_region_next  = wr_region_reg;
    done_next       = 1'b0;
    clear_mask      = 4'd0;
    case (state_reg)
      IDLE: begin
        if ((|pending_reg) && gate) begin
          slot_next             = pick_slot;
          code_next             = pick_code;
          row_next              = '0;
          clear_mask[pick_slot] = 1'b1;
          // Address is loaded on entry to RD so the ROM data is ready in CAP.
          glyph_addr_next       = {pick_code, {ROW_W{1'b0}}};
          state_next            = RD;
        end
      end
      RD: state_next = CAP;
      CAP: begin
        wr_data_next   = GlyphData;
        wr_fila_next   = row_reg;
        wr_region_next = slot_reg;
        wr_valid_next  = 1'b1;
        state_next     = WR;
      end
      WR: begin
        if (wr_valid_reg) begin
          if (WrReady) begin
            wr_valid_next = 1'b0;
            if (row_reg == LAST_ROW) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              row_next = row_reg + ROW_W'(1);
              if (gate) begin
                glyph_addr_next = {code_reg, row_reg + ROW_W'(1)};
                state_next      = RD;
              end
            end
          end
        end else if (gate) begin
          // Row already advanced; waiting for blanking before the next fetch.
          glyph_addr_next = {code_reg, row_reg};
          state_next      = RD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg      <= IDLE;
      sync1_reg      <= 4'd0;
      sync2_reg      <= 4'd0;
      prev_reg       <= 4'd0;
      selector_reg   <= 16'd0;
      pending_reg    <= 4'b1111;
      slot_reg       <= 2'd0;
      code_reg       <= 4'd0;
      row_reg        <= '0;
      glyph_addr_reg <= '0;
      wr_valid_reg   <= 1'b0;
      wr_data_reg    <= '0;
      wr_fila_reg    <= '0;
      wr_region_reg  <= 2'd0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sync1_reg      <= Letra;
      sync2_reg      <= sync1_reg;
      prev_reg       <= sync2_reg;
      selector_reg   <= selector_next;
      pending_reg    <= pending_next;
      slot_reg       <= slot_next;
      code_reg       <= code_next;
      row_reg        <= row_next;
      glyph_addr_reg <= glyph_addr_next;
      wr_valid_reg   <= wr_valid_next;
      wr_data_reg    <= wr_data_next;
      wr_fila_reg    <= wr_fila_next;
      wr_region_reg  <= wr_region_next;
      done_reg       <= done_next;
    end
  end

  assign GlyphAddr = glyph_addr_reg;
  assign WrValid   = wr_valid_reg;
  assign WrRegion  = wr_region_reg;
  assign WrFila    = wr_fila_reg;
  assign WrData    = wr_data_reg;
  assign Selector  = selector_reg;
  assign Busy      = (state_reg != IDLE);
  assign Done      = done_reg;

endmodule

// File: tb/tb_vram_glyph_writer.sv
// Self-checking bench for vram_glyph_writer: directed button/ready/reset
// stimulus, expected redraws queued by the stimulus and checked by a monitor.
module tb_vram_glyph_writer;
  localparam int FONT_W = 150;
  localparam int FONT_H = 523;
  localparam int ROW_W  = 10;

  logic               Clk = 1'b0;
  logic               Rst_n;
  logic [3:0]         Letra;
  logic               VBlank;
  logic [13:0]        GlyphAddr;
  logic [FONT_W-1:0]  GlyphData;
  logic               WrValid;
  logic               WrReady;
  logic [1:0]         WrRegion;
  logic [ROW_W-1:0]   WrFila;
  logic [FONT_W-1:0]  WrData;
  logic [15:0]        Selector;
  logic               Busy;
  logic               Done;

  vram_glyph_writer #(.FONT_W(FONT_W), .FONT_H(FONT_H), .ROW_W(ROW_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Letra(Letra), .VBlank(VBlank),
    .GlyphAddr(GlyphAddr), .GlyphData(GlyphData), .WrValid(WrValid),
    .WrReady(WrReady), .WrRegion(WrRegion), .WrFila(WrFila), .WrData(WrData),
    .Selector(Selector), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Glyph ROM model: row-index pattern with the code embedded.
  function automatic logic [FONT_W-1:0] pattern(input logic [13:0] a);
    return {a, 122'd0, a};
  endfunction

  always @(posedge Clk) GlyphData <= pattern(GlyphAddr);

  typedef struct {
    logic [1:0] region;
    logic [3:0] code;
  } redraw_t;

  redraw_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic [3:0] c);
    redraw_t e;
    e.region = r;
    e.code   = c;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every accepted write against the head redraw.
  int  mon_row = 0;
  logic exp_done = 1'b0;
  always @(negedge Clk) begin
    if (!Rst_n) begin
      mon_row  = 0;
      exp_done = 1'b0;
    end else begin
      if (Done || exp_done) begin
        checks++;
        if (Done !== exp_done) begin
          errors++;
          $display("FAIL done_pulse actual=%0b required=%0b", Done, exp_done);
        end
      end
      if (Done) done_seen++;
      exp_done = 1'b0;
      if (WrValid && WrReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual region=%0d row=%0d required none", WrRegion, WrFila);
        end else begin
          redraw_t h;
          logic [FONT_W-1:0] d;
          h = exp_q[0];
          d = pattern({h.code, ROW_W'(mon_row)});
          if (WrRegion !== h.region || WrFila !== ROW_W'(mon_row) || WrData !== d) begin
            errors++;
            $display("FAIL write actual region=%0d row=%0d data=%0h required region=%0d row=%0d data=%0h",
                     WrRegion, WrFila, WrData, h.region, mon_row, d);
          end
          if (mon_row == FONT_H - 1) begin
            $display("redraw region=%0d code=%0h complete", h.region, h.code);
            void'(exp_q.pop_front());
            mon_row  = 0;
            exp_done = 1'b1;
          end else begin
            mon_row++;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !Busy) && n < 20000) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("wait_idle_timeout", 32'(n >= 20000), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic press(input int s);
    Letra[s] = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Letra[s] = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  // Waits (bounded) for a pending write at a given region/row, sampled #1 after an edge.
  task automatic wait_write(input logic [1:0] r, input int row, input string name);
    int n;
    n = 0;
    while (!(WrValid && WrRegion == r && WrFila == ROW_W'(row)) && n < 2000) begin
      @(posedge Clk); #1;
      n++;
    end
    chk(name, 32'(n >= 2000), 32'd0);
  endtask

  initial begin
    int base;
    int cyc;
    Rst_n   = 1'b0;
    Letra   = 4'hF;
    WrReady = 1'b1;
    VBlank  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_selector", 32'(Selector), 32'h0);
    chk("reset_wrvalid", 32'(WrValid), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_glyphaddr", 32'(GlyphAddr), 32'd0);

    for (int i = 0; i < 4; i++) push(2'(i), 4'd0);
    base = done_seen;
    Rst_n = 1'b1;
`ifdef VRAM_GLYPH_WRITER_VBLANK_GATE_EN
    begin
      int seen;
      seen = 0;
      repeat (100) begin
        @(posedge Clk); #1;
        if (WrValid) seen++;
      end
      chk("vblank_hold_no_write", 32'(seen), 32'd0);
      VBlank = 1'b1;
      cyc = 0;
      while (!WrValid && cyc < 10) begin
        @(posedge Clk); #1;
        cyc++;
      end
      chk("vblank_start_within_3", 32'(cyc <= 3 && WrValid), 32'd1);
    end
`else
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (Done) break;
    end
    chk("first_done_latency", 32'(cyc), 32'd1570);
`endif
    wait_idle();
    chk("init_done_count", 32'(done_seen - base), 32'd4);
    chk("init_selector", 32'(Selector), 32'h0000);

    // Three presses on slot 2: one redraw with code 1, one extra with code 3.
    push(2'd2, 4'd1);
    press(2);
    push(2'd2, 4'd3);
    press(2);
    press(2);
    chk("slot2_selector", 32'(Selector[11:8]), 32'd3);

    // Stall the row-5 write of region 2 for 10 cycles.
    wait_write(2'd2, 5, "stall_row5_timeout");
    WrReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      chk("stall_wrvalid", 32'(WrValid), 32'd1);
      chk("stall_wrfila", 32'(WrFila), 32'd5);
      chk("stall_wrdata_lo", WrData[31:0], pattern({4'd1, 10'd5})[31:0]);
      chk("stall_no_row6_fetch", 32'(GlyphAddr), 32'({4'd1, 10'd5}));
    end
    WrReady = 1'b1;
    @(posedge Clk); #1;
    chk("row6_after_transfer", 32'(GlyphAddr), 32'({4'd1, 10'd6}));
    base = done_seen;
    wait_idle();
    chk("slot2_done_count", 32'(done_seen - base), 32'd2);
    chk("slot2_selector_after", 32'(Selector), 32'h0300);

    // Sixteen presses on slot 0: code wraps back to 0.
    push(2'd0, 4'd1);
    for (int i = 0; i < 16; i++) press(0);
    push(2'd0, 4'd0);
    chk("slot0_wrap_selector", 32'(Selector), 32'h0300);
    wait_idle();

    // Reset in the middle of a slot-1 redraw.
    push(2'd1, 4'd1);
    press(1);
    chk("slot1_selector", 32'(Selector), 32'h0310);
    wait_write(2'd1, 200, "row200_timeout");
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midreset_wrvalid", 32'(WrValid), 32'd0);
    chk("midreset_busy", 32'(Busy), 32'd0);
    chk("midreset_selector", 32'(Selector), 32'h0);
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) push(2'(i), 4'd0);
    base = done_seen;
    Rst_n = 1'b1;
    wait_idle();
    chk("reinit_done_count", 32'(done_seen - base), 32'd4);
    chk("reinit_selector", 32'(Selector), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vram_glyph_writer.md
Name: vram_glyph_writer

Overview:
- Write side of the 4-slot hex glyph display.
- Keeps one 4-bit glyph code per slot, advanced by four letter buttons.
- On any code change it copies the matching glyph bitmap, row by row, from the glyph ROM into that slot's video RAM region.
- The VGA pixel reader scans the same video RAM, so the screen always shows the current codes.

Parameters:
- FONT_W, 150: glyph row width in bits; equals the VRAM region width.
- FONT_H, 523: glyph rows per region.
- ROW_W, 10: row index width; 2^ROW_W must be at least FONT_H.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Letra  in  4  raw letter buttons; bit i is slot i; active edge is falling.
- VBlank  in  1  vertical blanking flag from VGA timing; used only with the optional feature.
- GlyphAddr  out  4+ROW_W  glyph ROM address = {code, row}.
- GlyphData  in  FONT_W  glyph ROM data; synchronous ROM, valid 1 cycle after GlyphAddr.
- WrValid  out  1  VRAM row write request.
- WrReady  in  1  VRAM accepts the write; a transfer occurs when WrValid and WrReady are both 1.
- WrRegion  out  2  target slot/region 0..3.
- WrFila  out  ROW_W  target row.
- WrData  out  FONT_W  row bitmap, MSB = leftmost pixel.
- Selector  out  16  current codes; slot i at [4i+3:4i].
- Busy  out  1  a redraw is in progress.
- Done  out  1  one-cycle pulse after the last row of a slot is accepted.

Behaviour:
- Reset (async, Rst_n=0):
  - Selector=0; all outputs 0; FSM returns to IDLE.
  - Pending=4'b1111, so all slots draw glyph 0 after reset.
  - WrValid drops immediately, aborting any in-flight write.
- Button input:
  - Each Letra bit passes through a 2-FF synchronizer, then falling-edge detection (1-cycle pulse).
  - A pulse increments that slot's code modulo 16 (15 -> 0) and sets the slot's Pending bit.
  - Several slots may pulse in the same cycle; all are updated independently.
- Arbitration: in IDLE, the lowest-index Pending slot is chosen.
- FSM states:
  - IDLE: Busy=0. If any Pending bit is set, latch slot index and its code into working registers, clear that Pending bit, set row=0, go to RD.
  - RD: drive GlyphAddr={code,row}; go to CAP.
  - CAP: register GlyphData into WrData; set WrFila=row, WrRegion=slot, WrValid=1; go to WR.
  - WR: hold WrValid, WrData, WrFila and WrRegion stable until WrReady=1.
    - On transfer, if row==FONT_H-1: WrValid=0, Done=1 for one cycle, go to IDLE.
    - Otherwise: row+1, WrValid=0, go to RD.
- Busy=1 in every state except IDLE.
- Timing: with WrReady tied high, a row takes 3 cycles; a full glyph takes 1 + 3*FONT_H cycles from Pending to Done (1570 at defaults).
- A press on the slot being redrawn:
  - Selector updates at once and Pending is set again.
  - The current redraw finishes with the latched code, then the slot is redrawn with the new code.
- WrFila never exceeds FONT_H-1.
- GlyphAddr holds its last value outside RD.

Optional Feature:
- Macro: VRAM_GLYPH_WRITER_VBLANK_GATE_EN.
- Defined:
  - IDLE->RD and WR->RD transitions occur only while VBlank=1; otherwise the FSM waits in place.
  - A write already in WR still completes regardless of VBlank.
  - This prevents visible tearing during redraw.
- Undefined: VBlank is ignored; writes proceed back to back.

Test Plan:
- Release reset with WrReady=1 and GlyphData=row-index pattern:
  - 4*523 writes occur, regions 0,1,2,3 in order, each with GlyphAddr code 0.
  - 4 Done pulses; the first arrives 1570 cycles after reset release.
  - Selector=16'h0000.
- After idle, give 3 falling edges on Letra[2]:
  - Selector[11:8]=3.
  - Region 2 is redrawn with GlyphAddr[13:10]=3 once the initial pending redraws finish.
  - Each press during a redraw causes exactly one extra redraw.
- Give 16 falling edges on Letra[0]: code wraps to 0; the final redraw uses code 0.
- Hold WrReady=0 for 10 cycles in WR at row 5:
  - WrValid, WrFila=5 and WrData stay stable.
  - Row 6 is fetched only after the transfer.
- Assert Rst_n=0 mid-redraw at row 200 of slot 1:
  - WrValid=0 and Busy=0 immediately.
  - After release, the full 4-slot init redraw restarts at row 0.
- With the macro defined and VBlank=0: no WrValid in 100 cycles. Raise VBlank: writes begin within 3 cycles.
